// File: rtl/ntt_result_collector.sv
// NTT result collector: reduces PE_NUM-lane beats mod q and stores them even/odd-split for readback.
// Optional COLLECTOR_CHECK_EN adds an expected memory and a CHECK pass that counts mismatches.
module ntt_result_collector #(
    parameter int DW        = 32,
    parameter int PE_NUM    = 1,
    parameter int MAX_DEPTH = 10,
    parameter int QW        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [QW-1:0]          q,
    input  logic [3:0]             ring_depth,
    input  logic                   start,
    input  logic                   din_valid,
    input  logic [PE_NUM*DW-1:0]   din,
    input  logic                   rd_en,
    input  logic [MAX_DEPTH-1:0]   rd_addr,
    output logic [DW-1:0]          rd_data,
    output logic                   busy,
    output logic                   cap_done,
    output logic                   range_err,
    output logic                   cfg_err,
    output logic                   ovf,
    input  logic                   exp_we,
    input  logic [MAX_DEPTH-1:0]   exp_addr,
    input  logic [DW-1:0]          exp_data,
    output logic [MAX_DEPTH:0]     err_cnt
);
    localparam int AW     = MAX_DEPTH;
    localparam int AW1    = MAX_DEPTH + 1;
    localparam int DEPTH  = 1 << MAX_DEPTH;
    localparam int PE_LOG = $clog2(PE_NUM);
    localparam int CW     = (DW > QW + 1) ? DW : QW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_DONE} state_t;

`ifdef COLLECTOR_CHECK_EN
    localparam state_t CAP_EXIT = S_CHECK;
`else
    localparam state_t CAP_EXIT = S_DONE;
`endif

    state_t          state_q;
    logic [QW-1:0]   mod_q;
    logic [3:0]      depth_q;
    logic [AW1-1:0]  beat_q;
    logic [DW-1:0]   rd_data_q;
    logic            busy_q, cap_done_q, range_err_q, cfg_err_q, ovf_q;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [31:0]     depth_ext;
    logic            depth_ok, start_ok, cap_fire, last_beat, rd_open;
    logic [AW1-1:0]  n_words, beats_total;
    logic [AW1-1:0]  samp      [PE_NUM];
    logic [AW-1:0]   lane_addr [PE_NUM];
    logic [DW-1:0]   lane_x    [PE_NUM];
    logic [DW-1:0]   lane_val  [PE_NUM];
    logic [PE_NUM-1:0] lane_big;

    assign depth_ext   = {28'd0, ring_depth};
    assign depth_ok    = (depth_ext >= 32'(PE_LOG + 1)) && (depth_ext <= 32'(MAX_DEPTH));
    assign start_ok    = start && depth_ok;
    assign n_words     = AW1'(1) << depth_q;
    assign beats_total = n_words >> PE_LOG;
    assign cap_fire    = (state_q == S_CAPTURE) && din_valid && !start_ok;
    assign last_beat   = cap_fire && (beat_q == beats_total - AW1'(1));
    assign rd_open     = (state_q == S_IDLE) || (state_q == S_DONE);

    // Even samples fill the lower half, odd samples the upper half of the N-word window.
    always_comb begin
        for (int unsigned l = 0; l < PE_NUM; l++) begin
            samp[l]      = (beat_q << PE_LOG) + AW1'(l);
            lane_addr[l] = AW'((samp[l] >> 1) + (samp[l][0] ? (n_words >> 1) : '0));
            lane_x[l]    = din[l*DW +: DW];
            lane_big[l]  = CW'(lane_x[l]) >= (CW'(mod_q) << 1);
            lane_val[l]  = (CW'(lane_x[l]) >= CW'(mod_q)) ? lane_x[l] - DW'(mod_q) : lane_x[l];
        end
    end

    always_ff @(posedge clk) begin
        if (cap_fire) begin
            for (int unsigned l = 0; l < PE_NUM; l++) begin
                mem_q[lane_addr[l]] <= lane_val[l];
            end
        end
    end

`ifdef COLLECTOR_CHECK_EN
    logic [DW-1:0]  exp_mem_q [DEPTH];
    logic [AW1-1:0] chk_q;
    logic [AW1-1:0] err_cnt_q;
    logic           mismatch;

    always_ff @(posedge clk) begin
        if (exp_we) begin
            exp_mem_q[exp_addr] <= exp_data;
        end
    end

    assign mismatch = mem_q[chk_q[AW-1:0]] != exp_mem_q[chk_q[AW-1:0]];
    assign err_cnt  = err_cnt_q;
`else
    logic unused_exp;
    assign unused_exp = ^{exp_we, exp_addr, exp_data};
    assign err_cnt    = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mod_q       <= '0;
            depth_q     <= '0;
            beat_q      <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            cap_done_q  <= 1'b0;
            range_err_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef COLLECTOR_CHECK_EN
            chk_q       <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            if (rd_en) begin
                rd_data_q <= rd_open ? mem_q[rd_addr] : '0;
            end
            if (din_valid && state_q != S_CAPTURE) begin
                ovf_q <= 1'b1;
            end
            if (start && !depth_ok) begin
                cfg_err_q <= 1'b1;
            end
            if (start_ok) begin
                mod_q       <= q;
                depth_q     <= ring_depth;
                beat_q      <= '0;
                range_err_q <= 1'b0;
                state_q     <= S_CAPTURE;
                busy_q      <= 1'b1;
                cap_done_q  <= 1'b0;
`ifdef COLLECTOR_CHECK_EN
                chk_q       <= '0;
                err_cnt_q   <= '0;
`endif
            end else begin
                case (state_q)
                    S_CAPTURE: begin
                        if (cap_fire) begin
                            if (|lane_big) begin
                                range_err_q <= 1'b1;
                            end
                            beat_q <= beat_q + AW1'(1);
                            if (last_beat) begin
                                state_q    <= CAP_EXIT;
                                busy_q     <= (CAP_EXIT == S_CHECK);
                                cap_done_q <= (CAP_EXIT == S_DONE);
                            end
                        end
                    end
`ifdef COLLECTOR_CHECK_EN
                    S_CHECK: begin
                        if (mismatch) begin
                            err_cnt_q <= err_cnt_q + AW1'(1);
                        end
                        chk_q <= chk_q + AW1'(1);
                        if (chk_q == n_words - AW1'(1)) begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            cap_done_q <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign cap_done  = cap_done_q;
    assign range_err = range_err_q;
    assign cfg_err   = cfg_err_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_ntt_result_collector.sv
// Randomized bench for ntt_result_collector (PE_NUM=2) against a per-sample placement/reduction model.
module tb_ntt_result_collector;
    localparam int DW = 32, PE = 2, MD = 10, QW = 16, NMAX = 1 << MD;
`ifdef COLLECTOR_CHECK_EN
    localparam int CHECK_ON = 1;
`else
    localparam int CHECK_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [QW-1:0]     q;
    logic [3:0]        ring_depth;
    logic              start, din_valid, rd_en, exp_we;
    logic [PE*DW-1:0]  din;
    logic [MD-1:0]     rd_addr, exp_addr;
    logic [DW-1:0]     exp_data, rd_data;
    logic              busy, cap_done, range_err, cfg_err, ovf;
    logic [MD:0]       err_cnt;

    ntt_result_collector #(.DW(DW), .PE_NUM(PE), .MAX_DEPTH(MD), .QW(QW)) dut (
        .clk(clk), .reset(reset), .q(q), .ring_depth(ring_depth), .start(start),
        .din_valid(din_valid), .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .cap_done(cap_done), .range_err(range_err), .cfg_err(cfg_err), .ovf(ovf),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] smp     [NMAX];
    logic [DW-1:0] ref_mem [NMAX];
    logic          ref_range;
    int            ref_errs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] red(input longint unsigned x, input longint unsigned m);
        return (x >= m) ? DW'(x - m) : DW'(x);
    endfunction

    // Even sample s -> s/2, odd sample s -> N/2 + s/2; a sample >= 2q flags range_err.
    task automatic model(input int n, input int unsigned qq);
        ref_range = 1'b0;
        for (int s = 0; s < n; s++) begin
            int a;
            a = (s % 2 == 0) ? s / 2 : n / 2 + s / 2;
            ref_mem[a] = red(smp[s], qq);
            if (longint'(smp[s]) >= 2 * longint'(qq)) ref_range = 1'b1;
        end
        ref_errs = (CHECK_ON != 0 && n > 5) ? 1 : 0;
    endtask

    task automatic fill(input int n, input int unsigned qq, input bit big);
        for (int s = 0; s < n; s++)
            smp[s] = (big && $urandom_range(0, 9) == 0) ? $urandom_range(2 * qq, 3 * qq)
                                                        : $urandom_range(0, 2 * qq - 1);
    endtask

    task automatic do_start(input int d, input int unsigned qq);
        start = 1'b1; ring_depth = 4'(d); q = QW'(qq);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int count);
        for (int b = first; b < first + count; b++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            din = {smp[2*b+1], smp[2*b]};
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    task automatic rd(input int a, input logic [DW-1:0] e, input string tag);
        rd_en = 1'b1; rd_addr = MD'(a);
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rd_data, e);
    endtask

    task automatic capture(input int d, input int unsigned qq, input bit read_all);
        int n, k;
        n = 1 << d;
        model(n, qq);
        if (CHECK_ON != 0) begin
            for (int a = 0; a < n; a++) begin
                exp_we = 1'b1; exp_addr = MD'(a);
                exp_data = (a == 5) ? ref_mem[a] ^ 32'd1 : ref_mem[a];
                @(negedge clk);
            end
            exp_we = 1'b0;
        end
        do_start(d, qq);
        chk("busy_in_capture", busy, 1);
        feed(0, n / 2);
        k = 0;
        while (cap_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, (CHECK_ON != 0) ? n : 0);
        chk("busy_after_done", busy, 0);
        chk("range_err", range_err, ref_range);
        chk("err_cnt", err_cnt, ref_errs);
        if (read_all)
            for (int a = 0; a < n; a++) rd(a, ref_mem[a], "readback");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        reset = 1'b1; q = '0; ring_depth = '0; start = 0; din_valid = 0; din = '0;
        rd_en = 0; rd_addr = '0; exp_we = 0; exp_addr = '0; exp_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);         chk("rst_done", cap_done, 0);
        chk("rst_range", range_err, 0);  chk("rst_cfg", cfg_err, 0);
        chk("rst_ovf", ovf, 0);           chk("rst_err_cnt", err_cnt, 0);
        chk("rst_rd_data", rd_data, 0);

        // Illegal depths: too large, then too small for two lanes.
        do_start(11, 3329);
        chk("cfg_err_hi", cfg_err, 1);    chk("cfg_stays_idle", busy, 0);
        chk("cfg_no_done", cap_done, 0);
        din_valid = 1'b1; @(negedge clk); din_valid = 1'b0;
        chk("ovf_idle", ovf, 1);
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        chk("rst_clr_cfg", cfg_err, 0);   chk("rst_clr_ovf", ovf, 0);
        do_start(1, 3329);
        chk("cfg_err_lo", cfg_err, 1);    chk("cfg_lo_idle", busy, 0);

        // Ramp data, ring size 256.
        for (int s = 0; s < 256; s++) smp[s] = DW'(s);
        capture(8, 3329, 1'b0);
        rd(0, 0, "ramp_a0");     rd(128, 1, "ramp_a128");
        rd(127, 254, "ramp_a127"); rd(255, 255, "ramp_a255");
        held = rd_data;
        repeat (2) @(negedge clk);
        chk("rd_hold", rd_data, held);
        do_start(11, 3329);
        chk("cfg_in_done_keeps_done", cap_done, 1);
        din = {32'd77, 32'd77}; din_valid = 1'b1; @(negedge clk); din_valid = 1'b0;
        chk("ovf_done", ovf, 1);
        rd(0, 0, "ovf_discarded");
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        chk("rst_after_done", cap_done, 0);
        rd(255, 255, "buf_survives_reset");

        // Out-of-range and reducible samples.
        for (int s = 0; s < 256; s++) smp[s] = DW'(s);
        smp[0] = 3330; smp[2] = 6700;
        capture(8, 3329, 1'b0);
        rd(0, 1, "reduce_a0"); rd(1, 3371, "reduce_a1");
        chk("range_flag", range_err, 1);

        // Ring size 16: samples 6 and 7 share beat 3.
        fill(16, 3329, 1'b0);
        capture(4, 3329, 1'b1);
        rd(3, red(smp[6], 3329), "s6_addr3");
        rd(11, red(smp[7], 3329), "s7_addr11");

        // Restart mid-capture, including a read during CAPTURE.
        fill(64, 1000, 1'b1);
        do_start(6, 1000);
        feed(0, 10);
        rd(0, 0, "rd_in_capture");
        fill(128, 2027, 1'b1);
        capture(7, 2027, 1'b1);

        // Reset abandons a capture; a fresh one rewrites everything.
        fill(256, 3329, 1'b0);
        smp[3] = 9000;
        do_start(8, 3329);
        feed(0, 50);
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        chk("abandon_busy", busy, 0);     chk("abandon_done", cap_done, 0);
        chk("abandon_range", range_err, 0);
        fill(256, 3329, 1'b0);
        capture(8, 3329, 1'b1);

        // Random configurations.
        for (int i = 0; i < 4; i++) begin
            int d;
            int unsigned qq;
            d  = (i == 0) ? 10 : (i == 1) ? 2 : $urandom_range(2, 10);
            qq = $urandom_range(2, 65535);
            fill(1 << d, qq, 1'b1);
            capture(d, qq, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
